// File: rtl/rom.sv
// 16 x 4-bit constant lookup table with a registered, enable-gated read port.
// Define ROM_VALID_EN to add a vld output that qualifies data.
module rom #(
  parameter logic [3:0] RST_VAL = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] addr,
  output logic [3:0] data
`ifdef ROM_VALID_EN
  ,
  output logic       vld
`endif
);

  logic [3:0] rom_word;
  logic [3:0] data_d, data_q;

  // The default arm catches an X/Z address so data stays deterministic.
  always_comb begin
    case (addr)
      4'h0:    rom_word = 4'h2;
      4'h1:    rom_word = 4'h4;
      4'h2:    rom_word = 4'h6;
      4'h3:    rom_word = 4'h8;
      4'h4:    rom_word = 4'hA;
      4'h5:    rom_word = 4'hC;
      4'h6:    rom_word = 4'hE;
      4'h7:    rom_word = 4'h1;
      4'h8:    rom_word = 4'h3;
      4'h9:    rom_word = 4'h5;
      4'hA:    rom_word = 4'h7;
      4'hB:    rom_word = 4'h9;
      4'hC:    rom_word = 4'hB;
      4'hD:    rom_word = 4'hD;
      4'hE:    rom_word = 4'hF;
      4'hF:    rom_word = 4'h0;
      default: rom_word = 4'h0;
    endcase
  end

  always_comb begin
    data_d = data_q;
    if (en) data_d = rom_word;
  end

  always_ff @(posedge clk) begin
    if (rst) data_q <= RST_VAL;
    else     data_q <= data_d;
  end

  assign data = data_q;

`ifdef ROM_VALID_EN
  logic vld_q;

  always_ff @(posedge clk) begin
    if (rst) vld_q <= 1'b0;
    else     vld_q <= en;
  end

  assign vld = vld_q;
`endif

endmodule

// File: tb/tb_rom.sv
// Scoreboard bench for rom: stimulus pushes hand-computed expectations, a monitor
// pops and compares one result per clock after each rising edge.
module tb_rom;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] addr;
  logic [3:0] data;
`ifdef ROM_VALID_EN
  logic       vld;
`endif

  rom #(
    .RST_VAL(4'h0)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .addr (addr),
    .data (data)
`ifdef ROM_VALID_EN
    ,
    .vld  (vld)
`endif
  );

  typedef struct {
    logic [3:0] d;
    logic       v;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  logic [3:0] tbl [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expectation per rising edge, checked 1 time unit after it.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        total++;
        if (data !== e.d) begin
          bad++;
          $display("FAIL %s: data got %h want %h", e.name, data, e.d);
        end
`ifdef ROM_VALID_EN
        total++;
        if (vld !== e.v) begin
          bad++;
          $display("FAIL %s: vld got %b want %b", e.name, vld, e.v);
        end
`endif
      end
    end
  end

  task automatic drive(input logic r, input logic e, input logic [3:0] a,
                       input logic [3:0] exp_d, input logic exp_v, input string name);
    exp_t x;
    @(negedge clk);
    rst  = r;
    en   = e;
    addr = a;
    x.d = exp_d;
    x.v = exp_v;
    x.name = name;
    exp_q.push_back(x);
  endtask

  initial begin
    logic [3:0] xa;
    logic [3:0] xexp;
    int         budget;

    tbl = '{4'h2, 4'h4, 4'h6, 4'h8, 4'hA, 4'hC, 4'hE, 4'h1,
            4'h3, 4'h5, 4'h7, 4'h9, 4'hB, 4'hD, 4'hF, 4'h0};
    rst  = 1'b1;
    en   = 1'b0;
    addr = 4'h0;

    // Reset with en low.
    drive(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, "reset");

    // Back-to-back reads.
    drive(1'b0, 1'b1, 4'hA, 4'h7, 1'b1, "read_a");
    drive(1'b0, 1'b1, 4'h6, 4'hE, 1'b1, "read_6");
    drive(1'b0, 1'b1, 4'h3, 4'h8, 1'b1, "read_3");

    // Hold ignores addr, then resume.
    drive(1'b0, 1'b0, 4'hF, 4'h8, 1'b0, "hold_f");
    drive(1'b0, 1'b0, 4'h1, 4'h8, 1'b0, "hold_1");
    drive(1'b0, 1'b1, 4'h8, 4'h3, 1'b1, "read_8");

    // Unknown address: deterministic 0 where X exists, else the addressed entry.
    drive(1'b0, 1'b1, 4'h0, 4'h2, 1'b1, "read_0");
    xa   = 4'bxxxx;
    xexp = $isunknown(xa) ? 4'h0 : tbl[xa];
    drive(1'b0, 1'b1, xa, xexp, 1'b1, "read_x");

    // Reset dominates enable; entry F is itself 0.
    drive(1'b0, 1'b1, 4'h5, 4'hC, 1'b1, "read_5");
    drive(1'b1, 1'b1, 4'hF, 4'h0, 1'b0, "rst_over_en");
    drive(1'b0, 1'b1, 4'hF, 4'h0, 1'b1, "read_f");

    // Full sweep.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 4'(i), tbl[i], 1'b1, $sformatf("sweep_%0h", i));
    end

    // Reset with a nonzero word held, then hold after reset.
    drive(1'b0, 1'b1, 4'hE, 4'hF, 1'b1, "read_e");
    drive(1'b1, 1'b0, 4'hE, 4'h0, 1'b0, "reset_again");
    drive(1'b0, 1'b0, 4'h9, 4'h0, 1'b0, "hold_after_rst");

    @(negedge clk);
    en = 1'b0;
    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending %0d want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
